lut_fir_accumulator: RTL and testbench

Time-multiplexed FIR sum-of-products engine for the digital estimator, using lookup tables. Each group of G consecutive control bits from S_matrix selects one precomputed partial sum from that group's 2^G-entry coefficient table. Groups are processed LANES at a time and accumulated over several cycles. Arbitrary K is supported with automatic padding, and the output stage supports selectable saturation, which removes the per-N remainder instances.

---
 rtl/lut_fir_accumulator_if.sv | 48 ++++
 rtl/lut_fir_accumulator.sv | 188 ++++++++++++++++++
 tb/tb_lut_fir_accumulator.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_fir_accumulator_if.sv
// ----------------------------------------------------------------------------
// lut_fir_accumulator_if
//
// Request/result bundle for the LUT-based FIR sum-of-products engine.
//
// Handshake: the master raises start together with a valid S_matrix. The
// request is accepted on a rising clock edge where both start and ready are 1.
// S_matrix is captured only on that edge. lut_table must stay stable from the
// accepting edge until valid. Requests made while ready=0 are dropped, not
// queued. valid is a one-cycle pulse. sample and sat hold their values until
// the next valid.
//
// Signals:
//   start      master -> slave  request one sample
//   ready      slave  -> master engine can accept a request this edge
//   S_matrix   master -> slave  K control bits (one per tap)
//   lut_table  master -> slave  NUM_GROUPS*2^G signed entries, entry e at
//                               bits [e*W +: W], e = group*2^G + index
//   sample     slave  -> master signed result
//   valid      slave  -> master one-cycle pulse when sample updates
//   sat        slave  -> master clamp/wrap flag for the latest sample
// ----------------------------------------------------------------------------
interface lut_fir_accumulator_if #(
    parameter int K                 = 240,
    parameter int G                 = 3,
    parameter int WIDTH_COEFFICIENT = 32
);
    localparam int NUM_GROUPS = (K + G - 1) / G;
    localparam int TABLE_W    = NUM_GROUPS * (1 << G) * WIDTH_COEFFICIENT;

    logic                                start;
    logic                                ready;
    logic [K-1:0]                        S_matrix;
    logic [TABLE_W-1:0]                  lut_table;
    logic signed [WIDTH_COEFFICIENT-1:0] sample;
    logic                                valid;
    logic                                sat;

    modport master (
        output start, S_matrix, lut_table,
        input  ready, sample, valid, sat
    );

    modport slave (
        input  start, S_matrix, lut_table,
        output ready, sample, valid, sat
    );
endinterface

// File: rtl/lut_fir_accumulator.sv
// ----------------------------------------------------------------------------
// lut_fir_accumulator
//
// Time-multiplexed FIR sum-of-products engine. Each group of G control bits
// selects one precomputed partial sum from that group's 2^G-entry table.
// LANES groups are summed per cycle, and the total is accumulated over
// PASSES cycles. The output is then clamped (SATURATE=1) or wrapped
// (SATURATE=0) to WIDTH_COEFFICIENT bits.
//
// Ports:
//   clk          clock
//   resetn       asynchronous active-low reset
//   bus          lut_fir_accumulator_if.slave (start/ready request, S_matrix,
//                lut_table, sample/valid/sat result)
//   dbg_state_o  current FSM state (0=IDLE, 1=ACCUM, 2=DONE)
// ----------------------------------------------------------------------------
module lut_fir_accumulator #(
    parameter int K                 = 240,
    parameter int G                 = 3,
    parameter int LANES             = 16,
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int SATURATE          = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    lut_fir_accumulator_if.slave  bus,
    output logic [1:0]            dbg_state_o
);
    localparam int W          = WIDTH_COEFFICIENT;
    localparam int NUM_GROUPS = (K + G - 1) / G;
    localparam int PASSES     = (NUM_GROUPS + LANES - 1) / LANES;
    localparam int ACC_W      = W + $clog2(NUM_GROUPS) + 1;
    localparam int ENTRIES    = 1 << G;
    localparam int SLOTS      = PASSES * LANES;
    localparam int S_PAD_W    = SLOTS * G;
    localparam int PASS_W     = (PASSES > 1) ? $clog2(PASSES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PASS_W-1:0]       pass_q, pass_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [K-1:0]            s_q, s_d;
    logic signed [W-1:0]     sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    sat_q, sat_d;

    logic                    ready_w;
    logic                    last_pass;
    logic [S_PAD_W-1:0]      s_pad;
    logic signed [ACC_W-1:0] lane_val [LANES];
    logic signed [ACC_W-1:0] lane_sum;
    logic signed [ACC_W-1:0] final_sum;
    logic                    fits;
    logic signed [W-1:0]     clamped;
    logic signed [W-1:0]     result;

    assign ready_w   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign last_pass = (pass_q == PASS_W'(PASSES - 1));

    // Zero-extending the snapshot up to a whole number of lane slots forces
    // the index bits of taps beyond K to 0 without any per-bit masking.
    assign s_pad = S_PAD_W'(s_q);

    // ------------------------------------------------------------------
    // Lane datapath: lane l handles group pass*LANES + l this cycle.
    // Shifts are used instead of variable part-selects so that slots past
    // the last real group simply read zeros.
    // ------------------------------------------------------------------
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0]         grp;
        logic [G-1:0]        idx;
        logic [31:0]         entry_pos;
        logic signed [W-1:0] entry;

        assign grp       = 32'(pass_q) * 32'(LANES) + 32'(l);
        assign idx       = G'(s_pad >> (grp * 32'(G)));
        assign entry_pos = grp * 32'(ENTRIES) + 32'(idx);
        assign entry     = W'(bus.lut_table >> (entry_pos * 32'(W)));

        // Padding slots (group index past the table) add nothing.
        assign lane_val[l] = (grp < 32'(NUM_GROUPS)) ? ACC_W'(entry) : '0;
    end

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + lane_val[l];
        end
    end

    assign final_sum = acc_q + lane_sum;

    // The sum fits in W bits when every bit above the W-bit sign position
    // repeats that sign bit.
    assign fits = (final_sum[ACC_W-1:W-1] == '0) ||
                  (final_sum[ACC_W-1:W-1] == '1);

    always_comb begin
        clamped = final_sum[W-1:0];
        if (!fits) begin
            clamped = final_sum[ACC_W-1] ? {1'b1, {(W-1){1'b0}}}
                                         : {1'b0, {(W-1){1'b1}}};
        end
    end

    assign result = (SATURATE != 0) ? clamped : final_sum[W-1:0];

    // ------------------------------------------------------------------
    // Control FSM: next state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        acc_d    = acc_q;
        s_d      = s_q;
        sample_d = sample_q;
        sat_d    = sat_q;
        valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ACCUM;
                    s_d     = bus.S_matrix;
                    acc_d   = '0;
                    pass_d  = '0;
                end
            end
            ST_ACCUM: begin
                acc_d = final_sum;
                if (last_pass) begin
                    state_d  = ST_DONE;
                    sample_d = result;
                    sat_d    = !fits;
                    valid_d  = 1'b1;
                end else begin
                    pass_d = pass_q + PASS_W'(1);
                end
            end
            ST_DONE: begin
                // A request in DONE starts the next sample immediately.
                if (bus.start) begin
                    state_d = ST_ACCUM;
                    s_d     = bus.S_matrix;
                    acc_d   = '0;
                    pass_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            pass_q   <= '0;
            acc_q    <= '0;
            s_q      <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            acc_q    <= acc_d;
            s_q      <= s_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            sat_q    <= sat_d;
        end
    end

    assign bus.ready   = ready_w;
    assign bus.sample  = sample_q;
    assign bus.valid   = valid_q;
    assign bus.sat     = sat_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lut_fir_accumulator.sv
// ----------------------------------------------------------------------------
// tb_lut_fir_accumulator
//
// Five engine instances share one clock and reset:
//   dut_a  K=6  G=3 LANES=1 W=32 SATURATE=1  (PASSES=2)
//   dut_b  K=7  G=3 LANES=2 W=32 SATURATE=1  (PASSES=2, padded group/lane)
//   dut_c  K=6  G=3 LANES=1 W=8  SATURATE=1
//   dut_d  K=6  G=3 LANES=1 W=8  SATURATE=0
//   dut_m  default parameters (K=240, G=3, LANES=16, W=32 -> PASSES=5)
// Expected {sat, sample} words are pushed to exp_q when a request is driven
// and popped when the engine pulses valid.
// ----------------------------------------------------------------------------
module tb_lut_fir_accumulator;
    localparam int EXP_W = 33;
    localparam int M_K   = 240;
    localparam int M_ENT = 640;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [EXP_W-1:0] exp_q[$];

    logic signed [31:0] tbl_m [M_ENT];

    logic [1:0] dbg_a, dbg_b, dbg_c, dbg_d, dbg_m;

    lut_fir_accumulator_if #(.K(6), .G(3), .WIDTH_COEFFICIENT(32)) if_a ();
    lut_fir_accumulator_if #(.K(7), .G(3), .WIDTH_COEFFICIENT(32)) if_b ();
    lut_fir_accumulator_if #(.K(6), .G(3), .WIDTH_COEFFICIENT(8))  if_c ();
    lut_fir_accumulator_if #(.K(6), .G(3), .WIDTH_COEFFICIENT(8))  if_d ();
    lut_fir_accumulator_if #(.K(240), .G(3), .WIDTH_COEFFICIENT(32)) if_m ();

    lut_fir_accumulator #(.K(6), .G(3), .LANES(1), .WIDTH_COEFFICIENT(32), .SATURATE(1))
        dut_a (.clk(clk), .resetn(resetn), .bus(if_a.slave), .dbg_state_o(dbg_a));
    lut_fir_accumulator #(.K(7), .G(3), .LANES(2), .WIDTH_COEFFICIENT(32), .SATURATE(1))
        dut_b (.clk(clk), .resetn(resetn), .bus(if_b.slave), .dbg_state_o(dbg_b));
    lut_fir_accumulator #(.K(6), .G(3), .LANES(1), .WIDTH_COEFFICIENT(8), .SATURATE(1))
        dut_c (.clk(clk), .resetn(resetn), .bus(if_c.slave), .dbg_state_o(dbg_c));
    lut_fir_accumulator #(.K(6), .G(3), .LANES(1), .WIDTH_COEFFICIENT(8), .SATURATE(0))
        dut_d (.clk(clk), .resetn(resetn), .bus(if_d.slave), .dbg_state_o(dbg_d));
    lut_fir_accumulator #(.K(240), .G(3), .LANES(16), .WIDTH_COEFFICIENT(32), .SATURATE(1))
        dut_m (.clk(clk), .resetn(resetn), .bus(if_m.slave), .dbg_state_o(dbg_m));

    // ------------------------------------------------------------------
    // Driver helpers for the default-parameter instance
    // ------------------------------------------------------------------
    task automatic fill_main_table(input int mode);
        for (int e = 0; e < M_ENT; e++) begin
            case (mode)
                0:       tbl_m[e] = $signed($urandom);
                1:       tbl_m[e] = $signed(32'($urandom_range(0, 2097151)) - 32'd1048576);
                default: tbl_m[e] = $signed(32'($urandom_range(0, 1073741823)) - 32'd536870912);
            endcase
            if_m.lut_table[e*32 +: 32] = tbl_m[e];
        end
    endtask

    // Reference: sum over groups of the entry picked by that group's taps,
    // taps at or beyond K contributing a 0 index bit; then clamp to 32 bits.
    function automatic logic [EXP_W-1:0] model_m(input logic [M_K-1:0] s);
        longint acc;
        int     idx;
        acc = 0;
        for (int g = 0; g < 80; g++) begin
            idx = 0;
            for (int j = 0; j < 3; j++) begin
                if ((g * 3 + j) < M_K && s[g*3+j]) idx = idx | (1 << j);
            end
            acc = acc + longint'(tbl_m[g*8+idx]);
        end
        if (acc > 64'sd2147483647)       return {1'b1, 32'h7fffffff};
        else if (acc < -64'sd2147483648) return {1'b1, 32'h80000000};
        else                             return {1'b0, acc[31:0]};
    endfunction

    function automatic logic [M_K-1:0] rand_s_m();
        logic [M_K-1:0] s;
        for (int i = 0; i < M_K; i++) s[i] = 1'($urandom_range(0, 1));
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        n_cmp++;
        if (if_a.ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_a: got %b want 1", if_a.ready); end
        n_cmp++;
        if (if_a.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_a: got %b want 0", if_a.valid); end
        n_cmp++;
        if (if_a.sample !== 32'sd0) begin n_err++; $display("FAIL reset_sample_a: got %0d want 0", if_a.sample); end
        n_cmp++;
        if (if_a.sat !== 1'b0) begin n_err++; $display("FAIL reset_sat_a: got %b want 0", if_a.sat); end
        n_cmp++;
        if (dbg_a !== 2'd0) begin n_err++; $display("FAIL reset_state_a: got %0d want 0", dbg_a); end
        n_cmp++;
        if (if_m.ready !== 1'b1 || if_m.valid !== 1'b0) begin
            n_err++; $display("FAIL reset_hs_m: got ready=%b valid=%b want 1/0", if_m.ready, if_m.valid);
        end
        n_cmp++;
        if (if_m.sample !== 32'sd0 || dbg_m !== 2'd0) begin
            n_err++; $display("FAIL reset_m: got sample=%0d state=%0d want 0/0", if_m.sample, dbg_m);
        end
    endtask

    // Two-group table g0[i]=i, g1[i]=10*i: result = idx0 + 10*idx1.
    task automatic test_basic();
        logic [5:0]       pats [3] = '{6'b011_101, 6'b000_000, 6'b111_010};
        logic [EXP_W-1:0] e, got;
        int               lat, v;
        if_a.lut_table = '0;
        for (int i = 0; i < 8; i++) begin
            if_a.lut_table[i*32 +: 32]     = 32'(i);
            if_a.lut_table[(8+i)*32 +: 32] = 32'(10 * i);
        end
        for (int k = 0; k < 3; k++) begin
            if_a.S_matrix = pats[k];
            v = int'(pats[k][2:0]) + 10 * int'(pats[k][5:3]);
            exp_q.push_back({1'b0, 32'(v)});
            if_a.start = 1'b1;
            @(negedge clk);
            if_a.start = 1'b0;
            if_a.S_matrix = ~pats[k];
            lat = 0;
            while (!if_a.valid && lat < 20) begin @(negedge clk); lat++; end
            n_cmp++;
            if (lat != 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", lat); end
            e = exp_q.pop_front();
            got = {if_a.sat, if_a.sample};
            n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL basic_result: got %h want %h", got, e); end
            @(negedge clk);
            n_cmp++;
            if (if_a.valid !== 1'b0 || if_a.sample !== e[31:0]) begin
                n_err++; $display("FAIL basic_hold: got valid=%b sample=%0d want 0/%0d", if_a.valid, if_a.sample, $signed(e[31:0]));
            end
        end
    endtask

    // K=7: group 2 holds only tap 6, its upper index bits must read 0.
    task automatic test_padding();
        logic [6:0]       pats [3] = '{7'b1_000_000, 7'b1_011_101, 7'b0_000_000};
        int               vals [3] = '{-4, 31, 0};
        logic [EXP_W-1:0] e, got;
        int               lat;
        if_b.lut_table = '0;
        for (int i = 0; i < 8; i++) begin
            if_b.lut_table[i*32 +: 32]     = 32'(i);
            if_b.lut_table[(8+i)*32 +: 32] = 32'(10 * i);
            if_b.lut_table[(16+i)*32 +: 32] = (i == 0) ? 32'sd0 : (i == 1) ? -32'sd4 : 32'(5000 + i);
        end
        for (int k = 0; k < 3; k++) begin
            if_b.S_matrix = pats[k];
            exp_q.push_back({1'b0, 32'(vals[k])});
            if_b.start = 1'b1;
            @(negedge clk);
            if_b.start = 1'b0;
            lat = 0;
            while (!if_b.valid && lat < 20) begin @(negedge clk); lat++; end
            n_cmp++;
            if (lat != 2) begin n_err++; $display("FAIL pad_latency: got %0d want 2", lat); end
            e = exp_q.pop_front();
            got = {if_b.sat, if_b.sample};
            n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL pad_result: got %h want %h", got, e); end
            @(negedge clk);
        end
    endtask

    // 8-bit output: clamp (dut_c) versus wrap (dut_d) around the range edges.
    task automatic test_saturation();
        int                 ca [6] = '{100, -100, 100, -100, 100, 50};
        int                 cb [6] = '{100, -100, 27, -28, 28, -50};
        int                 sum, clampv, lat;
        logic               sat_e;
        logic signed [7:0]  lo8;
        logic [7:0]         r;
        logic [EXP_W-1:0]   e, got;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) begin
                r = 8'($urandom_range(0, 255));
                if_c.lut_table[i*8 +: 8] = r;
                if_d.lut_table[i*8 +: 8] = r;
            end
            if_c.lut_table[7*8 +: 8]  = 8'(ca[k]);
            if_d.lut_table[7*8 +: 8]  = 8'(ca[k]);
            if_c.lut_table[15*8 +: 8] = 8'(cb[k]);
            if_d.lut_table[15*8 +: 8] = 8'(cb[k]);
            if_c.S_matrix = 6'b111_111;
            if_d.S_matrix = 6'b111_111;
            sum    = ca[k] + cb[k];
            sat_e  = (sum > 127) || (sum < -128);
            clampv = (sum > 127) ? 127 : (sum < -128) ? -128 : sum;
            lo8    = 8'(sum);
            exp_q.push_back({sat_e, 32'(clampv)});
            exp_q.push_back({sat_e, 32'(lo8)});
            if_c.start = 1'b1;
            if_d.start = 1'b1;
            @(negedge clk);
            if_c.start = 1'b0;
            if_d.start = 1'b0;
            lat = 0;
            while (!if_c.valid && lat < 20) begin @(negedge clk); lat++; end
            n_cmp++;
            if (lat != 2 || if_d.valid !== 1'b1) begin
                n_err++; $display("FAIL sat_latency: got %0d valid_d=%b want 2/1", lat, if_d.valid);
            end
            e = exp_q.pop_front();
            got = {if_c.sat, 32'(if_c.sample)};
            n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL sat_clamp case%0d: got %h want %h", k, got, e); end
            e = exp_q.pop_front();
            got = {if_d.sat, 32'(if_d.sample)};
            n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL sat_wrap case%0d: got %h want %h", k, got, e); end
            @(negedge clk);
        end
    endtask

    // start held high while S changes every cycle. Each accept takes the S
    // present on its edge. A request is re-accepted in DONE, so valids are
    // spaced by the ACCUM cycles plus the DONE cycle.
    task automatic test_back_to_back();
        logic [5:0]       s;
        logic [EXP_W-1:0] e, got;
        int               cyc, pushed, nvalid, last_v, extra;
        for (int i = 0; i < 8; i++) begin
            if_a.lut_table[i*32 +: 32]     = 32'(i);
            if_a.lut_table[(8+i)*32 +: 32] = 32'(10 * i);
        end
        cyc = 0; pushed = 0; nvalid = 0; last_v = -1;
        if_a.start = 1'b1;
        while ((pushed < 3 || exp_q.size() > 0) && cyc < 100) begin
            if (if_a.valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL b2b_unexpected_valid: got valid with empty queue want none");
                end else begin
                    e = exp_q.pop_front();
                    got = {if_a.sat, if_a.sample};
                    n_cmp++;
                    if (got !== e) begin n_err++; $display("FAIL b2b_result: got %h want %h", got, e); end
                end
                if (last_v >= 0) begin
                    n_cmp++;
                    if (cyc - last_v != 3) begin n_err++; $display("FAIL b2b_spacing: got %0d want 3", cyc - last_v); end
                end
                last_v = cyc;
                nvalid++;
            end
            if (pushed < 3) begin
                s = 6'($urandom_range(0, 63));
                if_a.S_matrix = s;
                if (if_a.ready) begin
                    exp_q.push_back({1'b0, 32'(int'(s[2:0]) + 10 * int'(s[5:3]))});
                    pushed++;
                end
            end else begin
                if_a.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        if_a.start = 1'b0;
        n_cmp++;
        if (nvalid != 3 || exp_q.size() != 0) begin
            n_err++; $display("FAIL b2b_count: got %0d valids (%0d pending) want 3 (0)", nvalid, exp_q.size());
            exp_q.delete();
        end
        extra = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (if_a.valid) extra++; end
        n_cmp++;
        if (extra != 0) begin n_err++; $display("FAIL b2b_extra_valid: got %0d want 0", extra); end
    endtask

    // Reset during the second ACCUM pass discards the sample.
    task automatic test_reset_mid();
        logic [M_K-1:0]   s;
        logic [EXP_W-1:0] e, got;
        int               saw_valid, lat;
        fill_main_table(1);
        s = rand_s_m();
        if_m.S_matrix = s;
        if_m.start = 1'b1;
        @(negedge clk);
        if_m.start = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        saw_valid = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (if_m.valid) saw_valid++; end
        n_cmp++;
        if (if_m.ready !== 1'b1 || dbg_m !== 2'd0) begin
            n_err++; $display("FAIL rstmid_idle: got ready=%b state=%0d want 1/0", if_m.ready, dbg_m);
        end
        n_cmp++;
        if (saw_valid != 0) begin n_err++; $display("FAIL rstmid_valid: got %0d pulses want 0", saw_valid); end
        n_cmp++;
        if (if_m.sample !== 32'sd0 || if_m.sat !== 1'b0) begin
            n_err++; $display("FAIL rstmid_sample: got %0d sat=%b want 0/0", if_m.sample, if_m.sat);
        end
        s = rand_s_m();
        if_m.S_matrix = s;
        exp_q.push_back(model_m(s));
        if_m.start = 1'b1;
        @(negedge clk);
        if_m.start = 1'b0;
        lat = 0;
        while (!if_m.valid && lat < 40) begin @(negedge clk); lat++; end
        n_cmp++;
        if (lat != 5) begin n_err++; $display("FAIL rstmid_latency: got %0d want 5", lat); end
        e = exp_q.pop_front();
        got = {if_m.sat, if_m.sample};
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL rstmid_result: got %h want %h", got, e); end
        @(negedge clk);
    endtask

    // Default parameters: random S and tables in three magnitude regimes.
    task automatic test_random();
        logic [M_K-1:0]   s;
        logic [EXP_W-1:0] e, got;
        int               lat;
        for (int n = 0; n < 1000; n++) begin
            if (n % 50 == 0) fill_main_table((n / 50) % 3);
            s = rand_s_m();
            if_m.S_matrix = s;
            exp_q.push_back(model_m(s));
            if_m.start = 1'b1;
            @(negedge clk);
            if_m.start = 1'b0;
            if_m.S_matrix = ~s;
            lat = 0;
            while (!if_m.valid && lat < 40) begin @(negedge clk); lat++; end
            n_cmp++;
            if (lat != 5) begin n_err++; $display("FAIL rand_latency n=%0d: got %0d want 5", n, lat); end
            e = exp_q.pop_front();
            got = {if_m.sat, if_m.sample};
            n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL rand_result n=%0d: got %h want %h", n, got, e); end
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        resetn = 1'b0;
        if_a.start = 1'b0; if_a.S_matrix = '0; if_a.lut_table = '0;
        if_b.start = 1'b0; if_b.S_matrix = '0; if_b.lut_table = '0;
        if_c.start = 1'b0; if_c.S_matrix = '0; if_c.lut_table = '0;
        if_d.start = 1'b0; if_d.S_matrix = '0; if_d.lut_table = '0;
        if_m.start = 1'b0; if_m.S_matrix = '0; if_m.lut_table = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        test_reset();
        test_basic();
        test_padding();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "time limit");
    end

endmodule
